// File: rtl/pipe_mux_tree.sv
// Pipelined N_IN:1 channel-select tree with one register rank per level.
// Carries valid and the effective select alongside the data; an optional scan counter sweeps the channels.
module pipe_mux_tree #(
    parameter int WIDTH = 4,
    parameter int N_IN  = 8,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  auto_mode,
    input  logic                  stall,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic [SEL_W-1:0]      scan_idx
);

    logic [SEL_W-1:0] eff_sel;
    logic             advance;

    assign eff_sel = auto_mode ? scan_idx : sel;
    assign advance = !stall;

    // N_IN is a power of two, so the natural SEL_W-bit rollover is the wrap to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx <= '0;
        end else if (advance && in_valid && auto_mode) begin
            scan_idx <= scan_idx + 1'b1;
        end
    end

    for (genvar k = 1; k <= SEL_W; k++) begin : g_lvl
        localparam int NCH = N_IN >> k;

        logic [2*NCH*WIDTH-1:0] prev_data;
        logic                   prev_valid;
        logic [SEL_W-1:0]       prev_sel;
        logic [NCH*WIDTH-1:0]   data_d;
        logic [NCH*WIDTH-1:0]   data_q;
        logic                   valid_q;
        logic [SEL_W-1:0]       sel_q;

        if (k == 1) begin : g_src
            assign prev_data  = in_data;
            assign prev_valid = in_valid;
            assign prev_sel   = eff_sel;
        end else begin : g_src
            assign prev_data  = g_lvl[k-1].data_q;
            assign prev_valid = g_lvl[k-1].valid_q;
            assign prev_sel   = g_lvl[k-1].sel_q;
        end

        // Each level consumes the select bit of its own depth.
        always_comb begin
            data_d = '0;
            for (int j = 0; j < NCH; j++) begin
                data_d[j*WIDTH +: WIDTH] = prev_sel[k-1] ? prev_data[(2*j+1)*WIDTH +: WIDTH]
                                                         : prev_data[(2*j)*WIDTH +: WIDTH];
            end
        end

        // Data loads even for invalid beats; consumers qualify with valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                sel_q   <= '0;
            end else if (advance) begin
                data_q  <= data_d;
                valid_q <= prev_valid;
                sel_q   <= prev_sel;
            end
        end
    end

    assign out_valid = g_lvl[SEL_W].valid_q;
    assign out_data  = g_lvl[SEL_W].data_q;
    assign out_sel   = g_lvl[SEL_W].sel_q;

endmodule
